// File: rtl/ps2_game_pkg.sv
// Shared scancodes, key-bitmap indices and parser state encoding for the
// PS/2 game input path, plus helpers that map and apply key events.
package ps2_game_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_UP   = 8'h1D;
  localparam logic [7:0] SC_DN   = 8'h1B;
  localparam logic [7:0] SC_LF   = 8'h1C;
  localparam logic [7:0] SC_RT   = 8'h23;
  localparam logic [7:0] SC_FIRE = 8'h29;
  localparam logic [7:0] SC_STOP = 8'h15;
  localparam logic [7:0] SC_XUP  = 8'h75;
  localparam logic [7:0] SC_XDN  = 8'h72;
  localparam logic [7:0] SC_XLF  = 8'h6B;
  localparam logic [7:0] SC_XRT  = 8'h74;

  localparam int KEY_UP   = 0;
  localparam int KEY_DN   = 1;
  localparam int KEY_LF   = 2;
  localparam int KEY_RT   = 3;
  localparam int KEY_STOP = 4;
  localparam int KEY_FIRE = 5;

  localparam logic [5:0] DIR_MASK = 6'b001111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parse_state_e;

  // Keypad codes without the E0 prefix deliberately map to nothing.
  function automatic logic [5:0] key_mask(input logic [7:0] code, input logic ext);
    logic [5:0] m;
    m = 6'b000000;
    if (ext) begin
      case (code)
        SC_XUP:  m[KEY_UP] = 1'b1;
        SC_XDN:  m[KEY_DN] = 1'b1;
        SC_XLF:  m[KEY_LF] = 1'b1;
        SC_XRT:  m[KEY_RT] = 1'b1;
        default: m = 6'b000000;
      endcase
    end else begin
      case (code)
        SC_UP:   m[KEY_UP]   = 1'b1;
        SC_DN:   m[KEY_DN]   = 1'b1;
        SC_LF:   m[KEY_LF]   = 1'b1;
        SC_RT:   m[KEY_RT]   = 1'b1;
        SC_FIRE: m[KEY_FIRE] = 1'b1;
        SC_STOP: m[KEY_STOP] = 1'b1;
        default: m = 6'b000000;
      endcase
    end
    return m;
  endfunction

  // A stop make also drops every held direction.
  function automatic logic [5:0] apply_make(input logic [5:0] held, input logic [5:0] mask);
    logic [5:0] r;
    if (mask[KEY_STOP]) begin
      r = (held & ~DIR_MASK) | mask;
    end else begin
      r = held | mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// Prefix-aware PS/2 scancode parser maintaining the held-key bitmap
// {shoot, stop, right, left, down, up}.
module ps2_key_tracker
  import ps2_game_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic [5:0] held_keys
);

  parse_state_e state_r;
  parse_state_e state_nxt_s;
  logic [5:0]   held_r;
  logic [5:0]   held_nxt_s;
  logic [5:0]   mask_s;

  // Next parser state and bitmap; only strobe cycles advance anything.
  always_comb begin
    state_nxt_s = state_r;
    held_nxt_s  = held_r;
    mask_s      = key_mask(ps2_key_data, (state_r == EXT) || (state_r == EXT_BRK));
    if (ps2_key_pressed) begin
      case (state_r)
        IDLE: begin
          if (ps2_key_data == SC_EXT) begin
            state_nxt_s = EXT;
          end else if (ps2_key_data == SC_BRK) begin
            state_nxt_s = BRK;
          end else begin
            held_nxt_s = apply_make(held_r, mask_s);
          end
        end
        EXT: begin
          if (ps2_key_data == SC_BRK) begin
            state_nxt_s = EXT_BRK;
          end else begin
            held_nxt_s  = apply_make(held_r, mask_s);
            state_nxt_s = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          held_nxt_s  = held_r & ~mask_s;
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      held_nxt_s  = held_r;
    end
  end

  // Parser state and bitmap registers.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r <= IDLE;
      held_r  <= 6'b000000;
    end else begin
      state_r <= state_nxt_s;
      held_r  <= held_nxt_s;
    end
  end

  assign held_keys = held_r;

endmodule

// File: rtl/ps2_action_scheduler.sv
// Turns held keys into rate-limited movement steps and shots, each offered
// to the game engine over a valid/ready handshake.
module ps2_action_scheduler
  import ps2_game_pkg::*;
#(
  parameter int MOVE_PERIOD  = 2500000,
  parameter int SHOOT_PERIOD = 12500000,
  parameter int CNT_W        = 24
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       move_valid,
  output logic [3:0] move_dir,
  input  logic       move_ready,
  output logic       shoot_valid,
  input  logic       shoot_ready,
  output logic [5:0] held_keys
);

  localparam logic [CNT_W-1:0] MOVE_LOAD  = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [CNT_W-1:0] SHOOT_LOAD = CNT_W'(SHOOT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]       held_s;
  logic [3:0]       eff_dir_s;
  logic             move_raise_s;
  logic             shoot_raise_s;
  logic             move_valid_r;
  logic [3:0]       move_dir_r;
  logic [CNT_W-1:0] move_cnt_r;
  logic             shoot_valid_r;
  logic [CNT_W-1:0] shoot_cnt_r;

  ps2_key_tracker u_tracker (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .held_keys       (held_s)
  );

  // Opposing directions cancel; a request is raised only from idle with an expired counter.
  always_comb begin
    eff_dir_s         = 4'b0000;
    eff_dir_s[KEY_UP] = held_s[KEY_UP] & ~held_s[KEY_DN];
    eff_dir_s[KEY_DN] = held_s[KEY_DN] & ~held_s[KEY_UP];
    eff_dir_s[KEY_LF] = held_s[KEY_LF] & ~held_s[KEY_RT];
    eff_dir_s[KEY_RT] = held_s[KEY_RT] & ~held_s[KEY_LF];
    move_raise_s      = ~move_valid_r & (eff_dir_s != 4'b0000) & (move_cnt_r == CNT_ZERO);
    shoot_raise_s     = ~shoot_valid_r & held_s[KEY_FIRE] & (shoot_cnt_r == CNT_ZERO);
  end

  // Movement request register and repeat interval counter.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      move_valid_r <= 1'b0;
      move_dir_r   <= 4'b0000;
      move_cnt_r   <= CNT_ZERO;
    end else if (move_raise_s) begin
      move_valid_r <= 1'b1;
      move_dir_r   <= eff_dir_s;
      move_cnt_r   <= MOVE_LOAD;
    end else begin
      if (move_valid_r && move_ready) begin
        move_valid_r <= 1'b0;
      end
      if (move_cnt_r != CNT_ZERO) begin
        move_cnt_r <= move_cnt_r - CNT_ONE;
      end
    end
  end

  // Shot request register and cooldown counter.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      shoot_valid_r <= 1'b0;
      shoot_cnt_r   <= CNT_ZERO;
    end else if (shoot_raise_s) begin
      shoot_valid_r <= 1'b1;
      shoot_cnt_r   <= SHOOT_LOAD;
    end else begin
      if (shoot_valid_r && shoot_ready) begin
        shoot_valid_r <= 1'b0;
      end
      if (shoot_cnt_r != CNT_ZERO) begin
        shoot_cnt_r <= shoot_cnt_r - CNT_ONE;
      end
    end
  end

  assign move_valid  = move_valid_r;
  assign move_dir    = move_dir_r;
  assign shoot_valid = shoot_valid_r;
  assign held_keys   = held_s;

endmodule

// File: tb/tb_ps2_action_scheduler.sv
// Directed bench with a handshake scoreboard for ps2_action_scheduler
// (MOVE_PERIOD=16, SHOOT_PERIOD=32).
module tb_ps2_action_scheduler;

  logic       CLOCK_50;
  logic       resetn;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       move_valid;
  logic [3:0] move_dir;
  logic       move_ready;
  logic       shoot_valid;
  logic       shoot_ready;
  logic [5:0] held_keys;

  typedef struct {
    logic [3:0] dir;
    int         gap;   // cycles since previous move handshake, 0 = any
  } mv_t;

  mv_t move_q[$];
  int  shot_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_move = 0;
  int  last_shot = 0;

  ps2_action_scheduler #(
    .MOVE_PERIOD  (16),
    .SHOOT_PERIOD (32),
    .CNT_W        (8)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .move_valid      (move_valid),
    .move_dir        (move_dir),
    .move_ready      (move_ready),
    .shoot_valid     (shoot_valid),
    .shoot_ready     (shoot_ready),
    .held_keys       (held_keys)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge CLOCK_50) begin
    mv_t e;
    int  g;
    if (resetn && move_valid && move_ready) begin
      n_vec++;
      if (move_q.size() == 0) begin
        n_err++;
        $display("FAIL move_extra: got handshake dir=%b, expected none", move_dir);
      end else begin
        e = move_q.pop_front();
        if (move_dir !== e.dir) begin
          n_err++;
          $display("FAIL move_dir: got %b, expected %b", move_dir, e.dir);
        end
        if (e.gap != 0) begin
          n_vec++;
          if (cyc - last_move != e.gap) begin
            n_err++;
            $display("FAIL move_gap: got %0d, expected %0d", cyc - last_move, e.gap);
          end
        end
      end
      last_move = cyc;
    end
    if (resetn && shoot_valid && shoot_ready) begin
      n_vec++;
      if (shot_q.size() == 0) begin
        n_err++;
        $display("FAIL shot_extra: got handshake, expected none");
      end else begin
        g = shot_q.pop_front();
        if (g != 0 && cyc - last_shot != g) begin
          n_err++;
          $display("FAIL shot_gap: got %0d, expected %0d", cyc - last_shot, g);
        end
      end
      last_shot = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    tick(1);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_move(input logic [3:0] d, input int g);
    mv_t e;
    e.dir = d;
    e.gap = g;
    move_q.push_back(e);
  endtask

  initial begin
    resetn          = 1'b0;
    ps2_key_data    = 8'h00;
    ps2_key_pressed = 1'b0;
    move_ready      = 1'b0;
    shoot_ready     = 1'b1;
    tick(2);
    resetn = 1'b1;
    chk("rst_move_valid", {7'd0, move_valid}, 8'h00);
    chk("rst_move_dir", {4'd0, move_dir}, 8'h00);
    chk("rst_shoot_valid", {7'd0, shoot_valid}, 8'h00);
    chk("rst_held", {2'd0, held_keys}, 8'h00);

    // Held up: first step right away, then one every 16 cycles.
    move_ready = 1'b1;
    push_move(4'b0001, 0);
    push_move(4'b0001, 16);
    push_move(4'b0001, 16);
    push_move(4'b0001, 16);
    send(8'h1D);
    tick(1);
    chk("up_first_valid", {7'd0, move_valid}, 8'h01);
    chk("up_first_dir", {4'd0, move_dir}, 8'h01);
    tick(50);
    send(8'hF0);
    send(8'h1D);

    // Left+right cancel while the interval is still running.
    send(8'h1C);
    send(8'h23);
    tick(20);
    chk("lr_cancel_valid", {7'd0, move_valid}, 8'h00);
    chk("lr_held", {2'd0, held_keys}, 8'h0C);
    push_move(4'b0100, 0);
    push_move(4'b0100, 16);
    send(8'hF0);
    send(8'h23);
    tick(20);
    send(8'hF0);
    send(8'h1C);

    // Extended up under a stalled engine; release does not retract it.
    move_ready = 1'b0;
    send(8'hE0);
    send(8'h75);
    tick(20);
    chk("stall_valid_a", {7'd0, move_valid}, 8'h01);
    chk("stall_dir_a", {4'd0, move_dir}, 8'h01);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    tick(20);
    chk("stall_valid_b", {7'd0, move_valid}, 8'h01);
    chk("stall_dir_b", {4'd0, move_dir}, 8'h01);
    push_move(4'b0001, 0);
    move_ready = 1'b1;
    tick(3);
    chk("stall_done", {7'd0, move_valid}, 8'h00);
    send(8'h75);
    tick(20);
    chk("keypad_held", {2'd0, held_keys}, 8'h00);
    chk("keypad_valid", {7'd0, move_valid}, 8'h00);

    // Held shoot with typematic repeats: shots exactly 32 cycles apart.
    shot_q.push_back(0);
    shot_q.push_back(32);
    shot_q.push_back(32);
    send(8'h29);
    for (int i = 0; i < 14; i++) begin
      tick(4);
      send(8'h29);
    end
    send(8'hF0);
    send(8'h29);
    tick(2);
    send(8'h29);
    send(8'hF0);
    send(8'h29);
    tick(40);
    chk("cooldown_shoot_valid", {7'd0, shoot_valid}, 8'h00);

    // Stop clears directions; the step raised by up still completes.
    push_move(4'b0001, 0);
    send(8'h1D);
    send(8'h1C);
    send(8'h15);
    tick(2);
    chk("stop_held", {2'd0, held_keys}, 8'h10);
    chk("stop_valid", {7'd0, move_valid}, 8'h00);
    send(8'hF0);
    send(8'h15);
    chk("stop_break_held", {2'd0, held_keys}, 8'h00);

    // Reset discards a half-received E0 prefix.
    send(8'hE0);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    push_move(4'b0001, 0);
    send(8'h1D);
    tick(3);
    chk("post_reset_up", {2'd0, held_keys}, 8'h01);
    send(8'hF0);
    send(8'h1D);
    chk("post_reset_break", {2'd0, held_keys}, 8'h00);
    tick(30);

    chk("move_q_drained", 8'(move_q.size()), 8'h00);
    chk("shot_q_drained", 8'(shot_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
